// File: rtl/up_dn_counter_ctrl_if.sv
// Request and counter-command bundle between a requester/counter pair and up_dn_counter_ctrl.
// The master side drives requests and counter status. The slave side is the controller.
interface up_dn_counter_ctrl_if;
  logic       req_valid;
  logic [4:0] req_target;
  logic       req_mode;
  logic       req_ready;
  logic [4:0] counter;
  logic       high;
  logic       low;
  logic [4:0] in_value;
  logic       load;
  logic       up;
  logic       down;
  logic       done;
  logic       err;

  modport master (
    output req_valid, req_target, req_mode, counter, high, low,
    input  req_ready, in_value, load, up, down, done, err
  );

  modport slave (
    input  req_valid, req_target, req_mode, counter, high, low,
    output req_ready, in_value, load, up, down, done, err
  );
endinterface

// File: rtl/up_dn_counter_ctrl.sv
// Sequencer that drives an external up/down counter to a requested value, by jump or by unit ramp.
// Optional CTRL_TIMEOUT_EN adds a 6-bit watchdog that aborts requests stuck outside IDLE.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | Load pulse with captured target on IN
// STEP  | compare counter with target, issue Up/Down or finish
// WAIT  | command settles, then check the counter
// FIN   | Done or Err pulse, back to IDLE
module up_dn_counter_ctrl (
  input logic            clk,
  input logic            rst_n,
  up_dn_counter_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [4:0] target_q;
  logic       mode_q;
  logic       abort_q, abort_d;
  logic       ready_q;
  logic [4:0] in_q, in_d;
  logic       load_q, load_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       done_q;
  logic       err_q;
  logic       accept;
  logic       timeout;

  assign accept = (state_q == S_IDLE) && ready_q && bus.req_valid;

`ifdef CTRL_TIMEOUT_EN
  logic [5:0] wdog_q;

  // Set to 1 on accept so the count includes the accept cycle itself. At 62 the next edge reaches 63.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 6'd0;
    end else if (accept) begin
      wdog_q <= 6'd1;
    end else if ((state_q != S_IDLE) && (wdog_q != 6'd63)) begin
      wdog_q <= wdog_q + 6'd1;
    end
  end

  assign timeout = (state_q != S_IDLE) && (state_q != S_FIN) && (wdog_q == 6'd62);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    in_d    = in_q;
    load_d  = 1'b0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          abort_d = 1'b0;
          if (bus.req_mode) begin
            state_d = S_STEP;
          end else begin
            state_d = S_LOAD;
            load_d  = 1'b1;
            in_d    = bus.req_target;
          end
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_STEP: begin
        if (bus.counter < target_q) begin
          if (bus.high) begin
            abort_d = 1'b1;
            state_d = S_FIN;
          end else begin
            up_d    = 1'b1;
            state_d = S_WAIT;
          end
        end else if (bus.counter > target_q) begin
          if (bus.low) begin
            abort_d = 1'b1;
            state_d = S_FIN;
          end else begin
            down_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_FIN;
        end
      end
      S_WAIT: begin
        if (bus.counter == target_q) begin
          state_d = S_FIN;
        end else if (mode_q) begin
          state_d = S_STEP;
        end else begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_FIN;
      abort_d = 1'b1;
      up_d    = 1'b0;
      down_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= 5'd0;
      mode_q   <= 1'b0;
      abort_q  <= 1'b0;
      ready_q  <= 1'b0;
      in_q     <= 5'd0;
      load_q   <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      ready_q <= (state_d == S_IDLE);
      in_q    <= in_d;
      load_q  <= load_d;
      up_q    <= up_d;
      down_q  <= down_d;
      done_q  <= (state_q == S_FIN) && !abort_q;
      err_q   <= (state_q == S_FIN) && abort_q;
      if (accept) begin
        target_q <= bus.req_target;
        mode_q   <= bus.req_mode;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.in_value  = in_q;
  assign bus.load      = load_q;
  assign bus.up        = up_q;
  assign bus.down      = down_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_up_dn_counter_ctrl.sv
// Scoreboard bench for up_dn_counter_ctrl with a behavioural up/down counter and a request-level reference model.
// Build with CTRL_TIMEOUT_EN defined to exercise the watchdog case.
module tb_up_dn_counter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  up_dn_counter_ctrl_if bus();
  up_dn_counter_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int acc;
    int lat;
    bit is_err;
    int tgt;
    int ups;
    int downs;
    int loads;
    int fin;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int seen_cnt = 0;
  int n_up = 0, n_dn = 0, n_ld = 0;

  logic [4:0] cnt = 5'd0;
  logic [4:0] preset_val = 5'd0;
  bit preset_en = 0, freeze = 0, fh = 0, fl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (preset_en) cnt <= preset_val;
    else if (!freeze) begin
      if (bus.load)      cnt <= bus.in_value;
      else if (bus.up)   cnt <= cnt + 5'd1;
      else if (bus.down) cnt <= cnt - 5'd1;
    end
  end

  assign bus.counter = cnt;
  assign bus.high    = fh | (cnt == 5'd31);
  assign bus.low     = fl | (cnt == 5'd0);

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  function automatic exp_t ref_model(input int a, input int b, input bit mode,
                                     input bit frz, input bit fhi, input bit flo);
    exp_t e;
    e.acc = 0; e.tgt = b; e.ups = 0; e.downs = 0; e.loads = 0; e.is_err = 0;
    e.lat = 0; e.fin = b;
    if (!mode) begin
      e.loads = 1;
      e.lat = 3;
      if (frz && a != b) begin e.is_err = 1; e.fin = -1; end
    end else if (a == b) begin
      e.lat = 2;
    end else if ((b > a && (fhi || a == 31)) || (b < a && (flo || a == 0))) begin
      e.is_err = 1; e.lat = 2; e.fin = a;
    end else begin
      if (b > a) begin e.ups = b - a; e.lat = 2 * (b - a) + 2; end
      else begin e.downs = a - b; e.lat = 2 * (a - b) + 2; end
    end
    return e;
  endfunction

  // Monitor: counts commands and checks each Done/Err against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    int sum;
    if (!rst_n) begin
      n_up = 0; n_dn = 0; n_ld = 0;
    end else begin
      sum = int'(bus.load) + int'(bus.up) + int'(bus.down);
      if (sum != 0) chk("single_cmd", sum, 1);
      if (bus.load) begin
        n_ld++;
        if (q.size() > 0) chk("load_in_value", int'(bus.in_value), q[0].tgt);
      end
      if (bus.up) n_up++;
      if (bus.down) n_dn++;
      if (bus.done || bus.err) begin
        seen_cnt++;
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: done=%0b err=%0b with nothing pending", bus.done, bus.err);
        end else begin
          e = q.pop_front();
          chk("err", int'(bus.err), int'(e.is_err));
          chk("done", int'(bus.done), int'(!e.is_err));
          chk("latency", cyc - e.acc, e.lat);
          if (e.ups >= 0) chk("up_pulses", n_up, e.ups);
          chk("down_pulses", n_dn, e.downs);
          chk("load_pulses", n_ld, e.loads);
          if (e.fin >= 0) chk("final_counter", int'(cnt), e.fin);
        end
        n_up = 0; n_dn = 0; n_ld = 0;
      end
    end
  end

  task automatic preset(input int v);
    @(negedge clk);
    preset_val = 5'(v);
    preset_en = 1;
    @(negedge clk);
    preset_en = 0;
  endtask

  task automatic issue(input int tgt, input bit mode, input exp_t e);
    int budget, prev;
    @(negedge clk);
    budget = 0;
    while (!bus.req_ready && budget < 50) begin @(negedge clk); budget++; end
    if (!bus.req_ready) begin expire("ready_wait"); return; end
    bus.req_valid = 1; bus.req_target = 5'(tgt); bus.req_mode = mode;
    e.acc = cyc + 1;
    q.push_back(e);
    prev = seen_cnt;
    @(negedge clk);
    budget = 0;
    // Random requests while busy must be ignored.
    while (seen_cnt == prev && budget < 300) begin
      if (bus.req_ready) bus.req_valid = 0;
      else begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_target = 5'($urandom);
        bus.req_mode = 1'($urandom);
      end
      @(negedge clk);
      budget++;
    end
    bus.req_valid = 0;
    if (seen_cnt == prev) expire("result_wait");
  endtask

  task automatic txn(input int a, input int b, input bit mode);
    preset(a);
    issue(b, mode, ref_model(a, b, mode, freeze, fh, fl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_release", int'(bus.req_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int prev;
    exp_t e;
    bus.req_valid = 0; bus.req_target = 5'd0; bus.req_mode = 0;
    #1 rst_n = 0;
    #11;
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_in", int'(bus.in_value), 0);
    chk("rst_load", int'(bus.load), 0);
    chk("rst_up", int'(bus.up), 0);
    chk("rst_down", int'(bus.down), 0);
    chk("rst_done_err", int'(bus.done) + int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_first_edge", int'(bus.req_ready), 1);

    txn(0, 5, 1);
    txn(5, 28, 0);
    txn(28, 28, 1);
    txn(31, 31, 1);
    txn(13, 2, 1);

    fh = 1;
    txn(30, 31, 1);
    fh = 0;
    fl = 1;
    txn(3, 0, 1);
    fl = 0;
    freeze = 1;
    txn(7, 19, 0);
    txn(9, 9, 0);
    freeze = 0;

    for (int i = 0; i < 20; i++)
      txn(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom));

    // Reset in the middle of a ramp from 10.
    preset(10);
    @(negedge clk);
    bus.req_valid = 1; bus.req_target = 5'd25; bus.req_mode = 1;
    @(negedge clk);
    bus.req_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.up) break;
    end
    chk("up_before_reset", int'(bus.up), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_up", int'(bus.up), 0);
    chk("mid_rst_down", int'(bus.down), 0);
    chk("mid_rst_load", int'(bus.load), 0);
    chk("mid_rst_ready", int'(bus.req_ready), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_mid_reset", int'(bus.req_ready), 1);
    txn(4, 6, 1);

    // Counter ignores commands: ramp 0 -> 20 never converges.
    preset(0);
    freeze = 1;
`ifdef CTRL_TIMEOUT_EN
    e = ref_model(0, 20, 1, 0, 0, 0);
    e.is_err = 1; e.lat = 63; e.ups = -1; e.downs = 0; e.loads = 0; e.fin = -1;
    issue(20, 1, e);
    freeze = 0;
    @(negedge clk);
    chk("ready_after_timeout", int'(bus.req_ready), 1);
`else
    @(negedge clk);
    bus.req_valid = 1; bus.req_target = 5'd20; bus.req_mode = 1;
    prev = seen_cnt;
    @(negedge clk);
    bus.req_valid = 0;
    repeat (200) @(negedge clk);
    chk("stuck_no_result", seen_cnt, prev);
    chk("stuck_not_idle", int'(bus.req_ready), 0);
    freeze = 0;
    do_reset();
`endif
    txn(20, 17, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
